rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 16x28 register file (R0 hardwired zero) between two writeback requesters: ALU (requester 0) and memory-return (requester 1).
- Arbitrates between them and drives a registered write port.
- Keeps a per-register pending-write scoreboard that issue logic queries for RAW/WAW hazards.
- Sits between the execute/load units and the register file inside the thread block.

Parameters:
- DATA_W, 28, width of a register / write data
- ADDR_W, 4, register index width
- NREG, 16, number of registers (must equal 2**ADDR_W)
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority, memory wins

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_dest  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU writeback data
- mem_valid  input  1  memory writeback request
- mem_ready  output  1  memory request accepted this cycle
- mem_dest  input  ADDR_W  memory destination register
- mem_data  input  DATA_W  memory writeback data
- rsv_valid  input  1  issue logic reserves a destination
- rsv_dest  input  ADDR_W  register being reserved
- busy  output  NREG  pending-write bit per register
- rf_wen  output  1  register-file write enable (to wen)
- rf_dest_sel  output  ADDR_W  register-file write index (to dest_sel)
- rf_data_in  output  DATA_W  register-file write data (to data_in)

Behaviour:
- Reset (async, rst=1): rf_wen=0, rf_dest_sel=0, rf_data_in=0, busy=0, RR pointer=0 (ALU favoured next). alu_ready and mem_ready are 0 while rst=1.
- Handshake: transfer occurs when valid and ready are both 1 in the same cycle.
  - ready is combinational from both valids and the RR pointer, never from the requester's own data.
  - A requester holds valid, dest and data stable until accepted.
- Arbitration, at most one grant per cycle:
  - Only one requester valid: it is granted.
  - Both valid with ROUND_ROBIN=1: grant goes to the requester not granted last. The pointer updates only on a grant.
  - Both valid with ROUND_ROBIN=0: mem is always granted.
- Write port, registered: a grant in cycle N sets, at the edge ending N, rf_wen=1, rf_dest_sel=dest and rf_data_in=data. These are visible during cycle N+1, so the RF writes at the end of N+1.
  - If there is no grant, rf_wen=0. rf_dest_sel and rf_data_in hold their last values.
  - Grant with dest=0: the request is accepted (ready=1) but dropped, so rf_wen=0 in N+1.
- Back-to-back grants produce rf_wen=1 on consecutive cycles. Throughput is 1 write/cycle, with no bubbles.
- Scoreboard:
  - busy[r] sets at the edge where rsv_valid=1 and rsv_dest=r. busy[0] is never set.
  - busy[r] clears at the edge ending the cycle in which rf_wen=1 and rf_dest_sel=r, i.e. when the RF write commits.
  - Set and clear of the same r at the same edge: set wins, because a new writer is pending.
  - Reservation of an already-busy register: busy stays 1, with no error.
- The block does not check that a writeback matches a reservation. Writes to non-busy registers are performed normally.
- Reset asserted mid-operation: an in-flight registered write is dropped (rf_wen=0 immediately), all busy bits clear, and the pointer returns to 0. Requesters must re-present after reset.

Test Plan:
- Reset: rst=1 for 2 cycles with both valids high -> alu_ready=mem_ready=0, rf_wen=0, busy=16'h0000. After release, with alu_valid only -> alu_ready=1.
- Single write: alu_valid, dest=5, data=28'h1234567 -> alu_ready=1 in cycle N. In N+1: rf_wen=1, rf_dest_sel=5, rf_data_in=28'h1234567. In N+2: rf_wen=0.
- Contention, RR: both valid for 4 cycles, alu dest=3 data=28'hAAAAAAA, mem dest=7 data=28'h5555555 -> grants alternate ALU, MEM, ALU, MEM. rf_wen stays 1 for 4 consecutive cycles with matching dest/data.
- Fixed priority (ROUND_ROBIN=0): both valid for 3 cycles -> mem_ready=1 and alu_ready=0 in every cycle.
- R0 drop: mem_valid, dest=0, data=28'hABCDE -> mem_ready=1, rf_wen stays 0.
- Scoreboard:
  - rsv dest=9 -> busy=16'h0200 next cycle.
  - ALU write to 9 -> busy[9] clears at the edge ending the rf_wen cycle.
  - rsv dest=9 in that same rf_wen cycle -> busy[9] remains 1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU
// (requester 0) and memory-return (requester 1) writeback paths. It drives a
// registered write port and keeps a per-register pending-write scoreboard.
// R0 is hardwired zero: writes to it are accepted and then dropped, and it is
// never marked busy. NREG must equal 2**ADDR_W.
module rf_wb_arbiter #(
  parameter int DATA_W      = 28,
  parameter int ADDR_W      = 4,
  parameter int NREG        = 16,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_dest,
  output logic [NREG-1:0]   busy,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_dest_sel,
  output logic [DATA_W-1:0] rf_data_in
);

  // Set when the ALU won the most recent grant. Reset to 0 so that the ALU
  // is favoured first.
  logic              alu_last;
  logic              alu_grant;
  logic              mem_grant;
  logic              any_grant;
  logic              wr_commit;
  logic [ADDR_W-1:0] grant_dest;
  logic [DATA_W-1:0] grant_data;
  logic [NREG-1:0]   busy_next;

  // Grant decision: uses only the two valids and the round-robin pointer.
  // Nothing is granted while reset is asserted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        if ((ROUND_ROBIN != 0) && !alu_last) alu_grant = 1'b1;
        else                                 mem_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
  end

  assign alu_ready  = alu_grant;
  assign mem_ready  = mem_grant;
  assign any_grant  = alu_grant | mem_grant;
  assign grant_dest = mem_grant ? mem_dest : alu_dest;
  assign grant_data = mem_grant ? mem_data : alu_data;
  // A grant to R0 consumes the request but produces no write.
  assign wr_commit  = any_grant && (grant_dest != '0);

  // Round-robin pointer: moves only when something is granted.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge regardless of block ordering.
    if (rst)            alu_last <= 1'b0;
    else if (any_grant) alu_last <= alu_grant;
  end

  // Registered write port. Index and data hold when nothing is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen      <= 1'b0;
      rf_dest_sel <= '0;
      rf_data_in  <= '0;
    end else begin
      rf_wen <= wr_commit;
      if (wr_commit) begin
        rf_dest_sel <= grant_dest;
        rf_data_in  <= grant_data;
      end
    end
  end

  // Scoreboard next state. The clear comes from the write being presented
  // to the RF this cycle. A reservation of the same register is applied
  // afterwards, so the new pending writer wins.
  always_comb begin
    busy_next = busy;
    if (rf_wen)    busy_next[rf_dest_sel] = 1'b0;
    if (rsv_valid) busy_next[rsv_dest]    = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule
